// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory request/ack plus the decode hand-off.
// master = fetch controller, slave = memory/decode environment.
// No logic here; timing is owned by the controller.
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer: picks next PC, drives imem req/ack, holds one instruction for decode.
// Latency: ack may land in the request cycle; instruction is valid the cycle after ack.
// Backpressure: held instruction waits while stall=1 or inst_ready=0; no new fetch until it leaves.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  pc_fetch_ctrl_if.master bus,
  output logic [31:0] pc
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic        req, req_nx;
  logic        valid, valid_nx;
  logic [31:0] inst, inst_nx;
  logic [31:0] inst_pc, inst_pc_nx;
  logic [31:0] pc_nx;
  logic        squash, squash_nx;
  logic [31:0] pending, pending_nx;

  logic        redirect;
  logic [31:0] target;
  logic        accept;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = inst;
  assign bus.inst_pc    = inst_pc;

  // Redirect source selection: trap beats jump beats branch; targets word-aligned.
  always_comb begin
    redirect = trap | jmp_valid | br_taken;
    if (trap)
      target = TRAP_VEC;
    else if (jmp_valid)
      target = jmp_target & 32'hFFFF_FFFC;
    else
      target = br_target & 32'hFFFF_FFFC;
    accept = bus.inst_ready & ~stall;
  end

  // Next-state logic. req=0 in FETCH is the single idle cycle before a request issues.
  always_comb begin
    state_nx   = state;
    req_nx     = req;
    valid_nx   = valid;
    inst_nx    = inst;
    inst_pc_nx = inst_pc;
    pc_nx      = pc;
    squash_nx  = squash;
    pending_nx = pending;
    case (state)
      FETCH: begin
        if (!req) begin
          // Nothing outstanding, so a redirect can retarget the PC directly.
          req_nx = 1'b1;
          if (redirect) pc_nx = target;
        end else if (bus.imem_ack) begin
          req_nx    = 1'b0;
          squash_nx = 1'b0;
          if (redirect) begin
            pc_nx = target;
          end else if (squash) begin
            pc_nx = pending;
          end else begin
            inst_nx    = bus.imem_rdata;
            inst_pc_nx = pc;
            valid_nx   = 1'b1;
            state_nx   = HOLD;
          end
        end else if (redirect) begin
          // Request stays in flight at the old address; its data will be dropped.
          pending_nx = target;
          squash_nx  = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_nx = 1'b0;
          pc_nx    = target;
          state_nx = FETCH;
          req_nx   = 1'b1;
        end else if (accept) begin
          valid_nx = 1'b0;
          pc_nx    = pc + 32'd4;
          state_nx = FETCH;
          req_nx   = 1'b1;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  // State register with synchronous reset; reset discards any in-flight ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      req     <= 1'b0;
      valid   <= 1'b0;
      inst    <= 32'h0;
      inst_pc <= 32'h0;
      pc      <= RESET_PC;
      squash  <= 1'b0;
      pending <= 32'h0;
    end else begin
      state   <= state_nx;
      req     <= req_nx;
      valid   <= valid_nx;
      inst    <= inst_nx;
      inst_pc <= inst_pc_nx;
      pc      <= pc_nx;
      squash  <= squash_nx;
      pending <= pending_nx;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios followed by random redirects/acks/stalls.
// A transaction-level model predicts fetch addresses and delivered instructions into queues;
// a monitor pops them when the DUT starts a request or presents an instruction.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, trap, jmp_valid, br_taken, stall;
  logic [31:0] jmp_target, br_target, pc;
  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .trap(trap), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .br_taken(br_taken), .br_target(br_target), .stall(stall), .bus(bus), .pc(pc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // IDLE: no fetch in flight, next one goes to m_addr.  WAIT: fetch of m_addr in flight.
  // HOLD: instruction fetched from m_addr is waiting for decode.
  typedef enum {M_IDLE, M_WAIT, M_HOLD} mphase_t;
  mphase_t     m_phase = M_IDLE;
  logic [31:0] m_addr = RESET_PC;
  bit          m_late_redir = 0;
  logic [31:0] m_late_tgt = 0;
  bit          exp_req = 0, exp_valid = 0;
  bit          mon_en = 0;
  logic [31:0] addr_q[$];
  logic [63:0] inst_q[$];

  function automatic logic [31:0] pick_target();
    if (trap) return TRAP_VEC;
    if (jmp_valid) return jmp_target & ~32'h3;
    return br_target & ~32'h3;
  endfunction

  task automatic model_step();
    bit          redir;
    logic [31:0] tgt;
    redir = trap | jmp_valid | br_taken;
    tgt   = pick_target();
    if (rst) begin
      m_phase = M_IDLE; m_addr = RESET_PC; m_late_redir = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (redir) m_addr = tgt;
          addr_q.push_back(m_addr);
          m_phase = M_WAIT;
        end
        M_WAIT: begin
          if (bus.imem_ack) begin
            // Any redirect seen during the fetch (latest wins, same-cycle one first) kills the data.
            if (redir) begin m_addr = tgt; m_phase = M_IDLE; end
            else if (m_late_redir) begin m_addr = m_late_tgt; m_phase = M_IDLE; end
            else begin inst_q.push_back({m_addr, bus.imem_rdata}); m_phase = M_HOLD; end
            m_late_redir = 0;
          end else if (redir) begin
            m_late_redir = 1; m_late_tgt = tgt;
          end
        end
        M_HOLD: begin
          if (redir || (bus.inst_ready && !stall)) begin
            m_addr = redir ? tgt : m_addr + 32'd4;
            addr_q.push_back(m_addr);
            m_phase = M_WAIT;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
    exp_req   = (m_phase == M_WAIT);
    exp_valid = (m_phase == M_HOLD);
  endtask

  task automatic drive(input bit r, input bit t, input bit j, input logic [31:0] jt,
                       input bit b, input logic [31:0] bt, input bit s, input bit rdy,
                       input bit a, input logic [31:0] d);
    @(negedge clk);
    rst = r; trap = t; jmp_valid = j; jmp_target = jt; br_taken = b; br_target = bt;
    stall = s; bus.inst_ready = rdy; bus.imem_ack = a; bus.imem_rdata = d;
    model_step();
  endtask

  task automatic tick(input bit a, input logic [31:0] d, input bit rdy, input bit s);
    drive(0, 0, 0, 32'h0, 0, 32'h0, s, rdy, a, d);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic        prev_req, prev_valid;
    logic [63:0] held;
    prev_req = 0; prev_valid = 0; held = 0;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        check("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
        check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_valid});
        check("pc", pc, m_addr);
        if (bus.imem_req && !prev_req) begin
          if (addr_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_addr: request at %h but none expected", bus.imem_addr);
          end else begin
            check("fetch_addr", bus.imem_addr, addr_q.pop_front());
          end
        end
        if (bus.inst_valid && !prev_valid) begin
          if (inst_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL inst_deliver: inst %h pc %h but none expected", bus.inst, bus.inst_pc);
          end else begin
            held = inst_q.pop_front();
          end
        end
        if (bus.inst_valid) begin
          check("inst", bus.inst, held[31:0]);
          check("inst_pc", bus.inst_pc, held[63:32]);
        end
        prev_req   = bus.imem_req;
        prev_valid = bus.inst_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit a, r, t, j, b;
    rst = 1; trap = 0; jmp_valid = 0; jmp_target = 0; br_taken = 0; br_target = 0;
    stall = 0; bus.inst_ready = 0; bus.imem_ack = 0; bus.imem_rdata = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_req", {31'b0, bus.imem_req}, 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);

    // First fetch acked in its request cycle, then stalled in HOLD for 3 cycles.
    tick(0, 0, 0, 0);
    tick(1, 32'h0000_0013, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(1, 32'h1111_1111, 1, 0);
    tick(0, 0, 1, 0);

    // Redirect race at pc=8: branch, then jump two cycles later, then the ack.
    drive(0, 0, 0, 0, 1, 32'h0000_0203, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
    drive(0, 0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(1, 32'h2222_2222, 1, 0);
    tick(0, 0, 1, 0);

    // At 0x40: jump with ack to 0x20, fetch there, then all three redirects in HOLD.
    drive(0, 0, 1, 32'h20, 0, 0, 0, 0, 1, 32'h3333_3333);
    tick(0, 0, 0, 0);
    tick(1, 32'h4444_4444, 0, 0);
    drive(0, 1, 1, 32'h80, 1, 32'hC0, 0, 1, 0, 0);

    // At 0x100: jump to the top word, fetch and accept, wrap to 0.
    drive(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 32'h5555_5555);
    tick(0, 0, 0, 0);
    tick(1, 32'h6666_6666, 0, 0);
    tick(0, 0, 1, 0);

    // Request at 0 outstanding, branch sets squash, reset with a late ack.
    drive(0, 0, 0, 0, 1, 32'h0000_0400, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    tick(0, 0, 0, 0);
    tick(1, 32'h8888_8888, 1, 0);
    tick(0, 0, 1, 0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      t = ($urandom_range(0, 29) == 0);
      j = ($urandom_range(0, 11) == 0);
      b = ($urandom_range(0, 7) == 0);
      a = (m_phase == M_WAIT) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      drive(r, t, j, $urandom, b, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0), a, $urandom);
    end
    tick(0, 0, 0, 0);
    @(posedge clk); #2;
    check("addr_q_drained", addr_q.size(), 32'h0);
    check("inst_q_drained", inst_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
